// File: rtl/mem_stage_unit_if.sv
// Bundle of the execute->memory->write-back handshake, SRAM read data and
// flush controls seen by the memory stage.
interface mem_stage_unit_if #(
  parameter int EX_ME_W = 78,
  parameter int ME_WB_W = 72
);
  // Valid/ready: a payload moves across a stage boundary on a rising clk edge
  // where the producer's valid and the consumer's allow_in are both high.
  logic               EX_to_ME_Valid;
  logic [EX_ME_W-1:0] EX_to_ME_Bus;
  logic               ME_Allow_in;
  logic               ME_to_WB_Valid;
  logic               WB_Allow_in;
  logic [ME_WB_W-1:0] ME_to_WB_Bus;
  logic [31:0]        data_sram_rdata;
  logic [4:0]         ME_dest;
  logic [31:0]        ME_Forward_Res;
  logic               ME_to_ID_Ld_op;
  logic               ME_has_excp;
  logic               excp_flush;
  logic               ertn_flush;

  modport master (
    output EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in, data_sram_rdata,
           excp_flush, ertn_flush,
    input  ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus, ME_dest,
           ME_Forward_Res, ME_to_ID_Ld_op, ME_has_excp
  );

  modport slave (
    input  EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in, data_sram_rdata,
           excp_flush, ertn_flush,
    output ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus, ME_dest,
           ME_Forward_Res, ME_to_ID_Ld_op, ME_has_excp
  );
endinterface

// File: rtl/mem_stage_unit.sv
// Memory-access pipeline stage: latches the execute payload, aligns/extends
// load data from the synchronous data SRAM, and holds that data across WB stalls.
module mem_stage_unit #(
  parameter int EX_ME_W = 78,
  parameter int ME_WB_W = 72
) (
  input logic            clk,
  input logic            reset,
  mem_stage_unit_if.slave bus
);

  logic               me_valid;
  logic [EX_ME_W-1:0] ex_bus_r;
  logic               first_cycle;
  logic [31:0]        rdata_hold;
  logic               hold_vld;

  logic        allow_in;
  logic        capture;
  logic        flush;

  logic        syscall;
  logic        ertn;
  logic        is_signed;
  logic        is_byte;
  logic        is_half;
  logic [1:0]  off;
  logic [31:0] pc;
  logic [31:0] result;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;

  logic [31:0] eff_rdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] mem_res;
  logic [31:0] final_result;
  logic [ME_WB_W-1:0] wb_bus;

  assign flush    = bus.excp_flush | bus.ertn_flush;
  assign allow_in = !me_valid | bus.WB_Allow_in;
  assign capture  = allow_in & bus.EX_to_ME_Valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      me_valid    <= 1'b0;
      ex_bus_r    <= '0;
      first_cycle <= 1'b0;
      rdata_hold  <= '0;
      hold_vld    <= 1'b0;
    end else begin
      if (flush)         me_valid <= 1'b0;
      else if (allow_in) me_valid <= bus.EX_to_ME_Valid;

      if (capture) ex_bus_r <= bus.EX_to_ME_Bus;

      first_cycle <= capture & !flush;

      // SRAM data is only valid the cycle after the address; keep it if WB stalls then.
      if (flush || capture) begin
        hold_vld <= 1'b0;
      end else if (me_valid && first_cycle && !bus.WB_Allow_in) begin
        rdata_hold <= bus.data_sram_rdata;
        hold_vld   <= 1'b1;
      end
    end
  end

  assign syscall      = ex_bus_r[77];
  assign ertn         = ex_bus_r[76];
  assign is_signed    = ex_bus_r[75];
  assign is_byte      = ex_bus_r[74];
  assign is_half      = ex_bus_r[73];
  assign off          = ex_bus_r[72:71];
  assign pc           = ex_bus_r[70:39];
  assign result       = ex_bus_r[38:7];
  assign res_from_mem = ex_bus_r[6];
  assign gr_we        = ex_bus_r[5];
  assign dest         = ex_bus_r[4:0];

  assign eff_rdata = hold_vld ? rdata_hold : bus.data_sram_rdata;
  assign half_sel  = off[1] ? eff_rdata[31:16] : eff_rdata[15:0];

  always_comb begin
    byte_sel = eff_rdata[7:0];
    case (off)
      2'd0: byte_sel = eff_rdata[7:0];
      2'd1: byte_sel = eff_rdata[15:8];
      2'd2: byte_sel = eff_rdata[23:16];
      2'd3: byte_sel = eff_rdata[31:24];
      default: byte_sel = eff_rdata[7:0];
    endcase
  end

  // Byte wins over half when both flags are set.
  always_comb begin
    mem_res = eff_rdata;
    if (is_byte)      mem_res = {{24{is_signed & byte_sel[7]}}, byte_sel};
    else if (is_half) mem_res = {{16{is_signed & half_sel[15]}}, half_sel};
  end

  assign final_result = res_from_mem ? mem_res : result;
  assign wb_bus       = {syscall, ertn, pc, final_result, gr_we, dest};

  assign bus.ME_Allow_in    = allow_in;
  assign bus.ME_to_WB_Valid = me_valid;
  assign bus.ME_to_WB_Bus   = wb_bus;
  assign bus.ME_dest        = dest & {5{me_valid}} & {5{gr_we}};
  assign bus.ME_Forward_Res = final_result;
  assign bus.ME_to_ID_Ld_op = me_valid & res_from_mem;
  assign bus.ME_has_excp    = me_valid & (syscall | ertn);

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: directed load/extension, stall-hold, flush and
// reset cases plus random back-to-back loads checked through an expected queue.
module tb_mem_stage_unit;

  logic clk;
  logic reset;

  mem_stage_unit_if #(.EX_ME_W(78), .ME_WB_W(72)) bus_if ();

  mem_stage_unit #(.EX_ME_W(78), .ME_WB_W(72)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [71:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every payload that crosses into write-back against the queue head.
  always @(negedge clk) begin
    if (!reset && bus_if.ME_to_WB_Valid && bus_if.WB_Allow_in) begin
      if (exp_q.size() == 0) check_val("unexpected_wb", 72'd1, 72'd0);
      else                   check_val("wb_bus", bus_if.ME_to_WB_Bus, exp_q.pop_front());
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [77:0] mk_ex(input logic sc, input logic er, input logic [4:0] flag,
                                        input logic [31:0] pc, input logic [31:0] res,
                                        input logic rfm, input logic we, input logic [4:0] dst);
    return {sc, er, flag, pc, res, rfm, we, dst};
  endfunction

  function automatic logic [71:0] mk_wb(input logic sc, input logic er, input logic [31:0] pc,
                                        input logic [31:0] fr, input logic we, input logic [4:0] dst);
    return {sc, er, pc, fr, we, dst};
  endfunction

  // Reference load extraction written as shifts rather than a byte mux.
  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [4:0] flag);
    logic [31:0] sh;
    if (flag[3]) begin
      sh = rd >> (8 * int'(flag[1:0]));
      return flag[4] ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
    end else if (flag[2]) begin
      sh = rd >> (flag[1] ? 16 : 0);
      return flag[4] ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
    end
    return rd;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus_if.EX_to_ME_Valid  = 1'b0;
    bus_if.EX_to_ME_Bus    = '0;
    bus_if.WB_Allow_in     = 1'b1;
    bus_if.data_sram_rdata = '0;
    bus_if.excp_flush      = 1'b0;
    bus_if.ertn_flush      = 1'b0;
  endtask

  // One load/ALU op with WB ready: capture, then present rdata for its ME cycle.
  task automatic issue(input string tag, input logic [77:0] b, input logic [31:0] rd,
                       input logic [31:0] exp_fr);
    bus_if.EX_to_ME_Valid = 1'b1;
    bus_if.EX_to_ME_Bus   = b;
    exp_q.push_back(mk_wb(b[77], b[76], b[70:39], exp_fr, b[5], b[4:0]));
    @(posedge clk); #1;
    bus_if.EX_to_ME_Valid  = 1'b0;
    bus_if.data_sram_rdata = rd;
    @(negedge clk);
    check_val(tag, {40'd0, bus_if.ME_Forward_Res}, {40'd0, exp_fr});
    @(posedge clk); #1;
    bus_if.data_sram_rdata = $urandom;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_valid"},  {71'd0, bus_if.ME_to_WB_Valid}, 72'd0);
    check_val({tag, "_dest"},   {67'd0, bus_if.ME_dest},        72'd0);
    check_val({tag, "_ldop"},   {71'd0, bus_if.ME_to_ID_Ld_op}, 72'd0);
    check_val({tag, "_excp"},   {71'd0, bus_if.ME_has_excp},    72'd0);
    check_val({tag, "_allow"},  {71'd0, bus_if.ME_Allow_in},    72'd1);
    check_val({tag, "_wb_bus"}, bus_if.ME_to_WB_Bus,            72'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [77:0] b;
  logic [31:0] rd;
  logic [31:0] pend_rd;
  logic [4:0]  flag;
  logic        v;

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;

    // word load with hazard/load-use outputs
    b = mk_ex(1'b0, 1'b0, 5'b00000, 32'h1C00_0040, 32'h0000_1000, 1'b1, 1'b1, 5'd5);
    bus_if.EX_to_ME_Valid = 1'b1;
    bus_if.EX_to_ME_Bus   = b;
    exp_q.push_back(mk_wb(1'b0, 1'b0, 32'h1C00_0040, 32'h8765_4321, 1'b1, 5'd5));
    @(posedge clk); #1;
    bus_if.EX_to_ME_Valid  = 1'b0;
    bus_if.data_sram_rdata = 32'h8765_4321;
    @(negedge clk);
    check_val("word_valid", {71'd0, bus_if.ME_to_WB_Valid}, 72'd1);
    check_val("word_res",   {40'd0, bus_if.ME_Forward_Res}, {40'd0, 32'h8765_4321});
    check_val("word_dest",  {67'd0, bus_if.ME_dest},        72'd5);
    check_val("word_ldop",  {71'd0, bus_if.ME_to_ID_Ld_op}, 72'd1);
    @(posedge clk); #1;

    // byte and half extensions
    issue("sbyte_off3", mk_ex(1'b0, 1'b0, 5'b11011, 32'h100, 32'h0, 1'b1, 1'b1, 5'd6), 32'h80FF_7F01, 32'hFFFF_FF80);
    issue("ubyte_off2", mk_ex(1'b0, 1'b0, 5'b01010, 32'h104, 32'h0, 1'b1, 1'b1, 5'd7), 32'h80FF_7F01, 32'h0000_00FF);
    issue("sbyte_off0", mk_ex(1'b0, 1'b0, 5'b11000, 32'h108, 32'h0, 1'b1, 1'b1, 5'd8), 32'h80FF_7F01, 32'h0000_0001);
    issue("shalf_off2", mk_ex(1'b0, 1'b0, 5'b10110, 32'h10C, 32'h0, 1'b1, 1'b1, 5'd9), 32'h9ABC_1234, 32'hFFFF_9ABC);
    issue("uhalf_off0", mk_ex(1'b0, 1'b0, 5'b00100, 32'h110, 32'h0, 1'b1, 1'b1, 5'd10), 32'h9ABC_1234, 32'h0000_1234);
    issue("byte_over_half", mk_ex(1'b0, 1'b0, 5'b11101, 32'h114, 32'h0, 1'b1, 1'b1, 5'd11), 32'h0000_8000, 32'hFFFF_FF80);

    // non-load with syscall: rdata must not leak into the result
    bus_if.EX_to_ME_Valid = 1'b1;
    bus_if.EX_to_ME_Bus   = mk_ex(1'b1, 1'b0, 5'b00000, 32'h200, 32'h0000_0042, 1'b0, 1'b1, 5'd12);
    exp_q.push_back(mk_wb(1'b1, 1'b0, 32'h200, 32'h0000_0042, 1'b1, 5'd12));
    @(posedge clk); #1;
    bus_if.EX_to_ME_Valid  = 1'b0;
    bus_if.data_sram_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_val("alu_res",     {40'd0, bus_if.ME_Forward_Res}, {40'd0, 32'h0000_0042});
    check_val("alu_excp",    {71'd0, bus_if.ME_has_excp},    72'd1);
    check_val("alu_bus71",   {71'd0, bus_if.ME_to_WB_Bus[71]}, 72'd1);
    check_val("alu_no_ldop", {71'd0, bus_if.ME_to_ID_Ld_op}, 72'd0);
    @(posedge clk); #1;

    // stall hold: rdata captured in the first ME cycle survives a 3-cycle stall
    bus_if.WB_Allow_in    = 1'b0;
    bus_if.EX_to_ME_Valid = 1'b1;
    bus_if.EX_to_ME_Bus   = mk_ex(1'b0, 1'b0, 5'b00000, 32'h300, 32'h0, 1'b1, 1'b1, 5'd13);
    @(posedge clk); #1;
    bus_if.EX_to_ME_Valid  = 1'b0;
    bus_if.data_sram_rdata = 32'h1122_3344;
    @(negedge clk);
    check_val("stall_c0_res",   {40'd0, bus_if.ME_Forward_Res}, {40'd0, 32'h1122_3344});
    check_val("stall_c0_allow", {71'd0, bus_if.ME_Allow_in},    72'd0);
    @(posedge clk); #1;
    bus_if.data_sram_rdata = 32'hDEAD_BEEF;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      check_val("stall_hold_res",   {40'd0, bus_if.ME_Forward_Res}, {40'd0, 32'h1122_3344});
      check_val("stall_hold_allow", {71'd0, bus_if.ME_Allow_in},    72'd0);
      @(posedge clk); #1;
    end
    exp_q.push_back(mk_wb(1'b0, 1'b0, 32'h300, 32'h1122_3344, 1'b1, 5'd13));
    bus_if.WB_Allow_in = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("stall_drained", {71'd0, bus_if.ME_to_WB_Valid}, 72'd0);
    @(posedge clk); #1;

    // flush while WB stalled discards the payload
    bus_if.WB_Allow_in    = 1'b0;
    bus_if.EX_to_ME_Valid = 1'b1;
    bus_if.EX_to_ME_Bus   = mk_ex(1'b0, 1'b1, 5'b00000, 32'h400, 32'h55, 1'b0, 1'b1, 5'd7);
    @(posedge clk); #1;
    bus_if.EX_to_ME_Valid = 1'b0;
    @(negedge clk);
    check_val("pre_flush_dest", {67'd0, bus_if.ME_dest}, 72'd7);
    bus_if.excp_flush = 1'b1;
    @(posedge clk); #1;
    bus_if.excp_flush = 1'b0;
    @(negedge clk);
    check_val("flush_valid", {71'd0, bus_if.ME_to_WB_Valid}, 72'd0);
    check_val("flush_dest",  {67'd0, bus_if.ME_dest},        72'd0);
    check_val("flush_excp",  {71'd0, bus_if.ME_has_excp},    72'd0);
    check_val("flush_allow", {71'd0, bus_if.ME_Allow_in},    72'd1);
    bus_if.WB_Allow_in = 1'b1;
    @(posedge clk); #1;

    // ertn flush racing a capture: flush wins
    bus_if.EX_to_ME_Valid = 1'b1;
    bus_if.EX_to_ME_Bus   = mk_ex(1'b0, 1'b0, 5'b00000, 32'h500, 32'h66, 1'b0, 1'b1, 5'd3);
    bus_if.ertn_flush     = 1'b1;
    @(posedge clk); #1;
    bus_if.EX_to_ME_Valid = 1'b0;
    bus_if.ertn_flush     = 1'b0;
    @(negedge clk);
    check_val("ertn_flush_valid", {71'd0, bus_if.ME_to_WB_Valid}, 72'd0);
    @(posedge clk); #1;

    // random back-to-back traffic with occasional bubbles, WB always ready
    pend_rd = '0;
    for (int i = 0; i < 40; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      rd = $urandom;
      case ($urandom_range(0, 2))
        0:       flag = {1'($urandom_range(0, 1)), 2'b10, 2'($urandom_range(0, 3))};
        1:       flag = {1'($urandom_range(0, 1)), 2'b01, 2'($urandom_range(0, 3))};
        default: flag = {1'($urandom_range(0, 1)), 2'b00, 2'($urandom_range(0, 3))};
      endcase
      b = mk_ex(1'b0, 1'b0, flag, $urandom, $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      if (v) exp_q.push_back(mk_wb(1'b0, 1'b0, b[70:39], b[6] ? model_load(rd, flag) : b[38:7], b[5], b[4:0]));
      bus_if.EX_to_ME_Valid  = v;
      bus_if.EX_to_ME_Bus    = b;
      bus_if.data_sram_rdata = pend_rd;
      pend_rd = rd;
      @(posedge clk); #1;
    end
    bus_if.EX_to_ME_Valid  = 1'b0;
    bus_if.data_sram_rdata = pend_rd;
    @(posedge clk); #1;

    // reset in the middle of a stalled load with its hold set
    bus_if.WB_Allow_in    = 1'b0;
    bus_if.EX_to_ME_Valid = 1'b1;
    bus_if.EX_to_ME_Bus   = mk_ex(1'b1, 1'b0, 5'b00000, 32'h600, 32'h0, 1'b1, 1'b1, 5'd9);
    @(posedge clk); #1;
    bus_if.EX_to_ME_Valid  = 1'b0;
    bus_if.data_sram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check_val("pre_reset_excp", {71'd0, bus_if.ME_has_excp}, 72'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    bus_if.data_sram_rdata = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    bus_if.WB_Allow_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    check_val("queue_drained", 72'(exp_q.size()), 72'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
